// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: memFunc bit indices, the
// W-stage write record and the access FSM state encoding.
package mem_stage_pkg;

  localparam int MEM_FUNC_W = 11;

  localparam int MF_LB  = 0;
  localparam int MF_LH  = 1;
  localparam int MF_LW  = 2;
  localparam int MF_LD  = 3;
  localparam int MF_LBU = 4;
  localparam int MF_LHU = 5;
  localparam int MF_LWU = 6;
  localparam int MF_SB  = 7;
  localparam int MF_SH  = 8;
  localparam int MF_SW  = 9;
  localparam int MF_SD  = 10;

  localparam logic [63:0] ZERO_64 = 64'd0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } rd_write_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: valid/ready request channel plus rvalid load response.
interface mem_stage_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  dmem_valid;
  logic                  dmem_ready;
  logic                  dmem_we;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [DATA_W-1:0]     dmem_wdata;
  logic [DATA_W/8-1:0]   dmem_wmask;
  logic                  dmem_rvalid;
  logic [DATA_W-1:0]     dmem_rdata;

  modport master (
    output dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store replication/mask, load extract/extend,
// and (with MEM_MISALIGN_CHECK_EN) natural-alignment detection.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [MEM_FUNC_W-1:0] mem_func_i,
  input  logic [2:0]            off_i,
  input  logic [63:0]           store_data_i,
  input  logic [63:0]           load_data_i,
  output logic [63:0]           wdata_o,
  output logic [7:0]            wmask_o,
  output logic [63:0]           load_value_o
`ifdef MEM_MISALIGN_CHECK_EN
  , output logic                misalign_o
`endif
);

  logic [63:0] field;

  always_comb begin
    wdata_o = store_data_i;
    wmask_o = 8'h00;
    if (mem_func_i[MF_SB]) begin
      wdata_o = {8{store_data_i[7:0]}};
      wmask_o = 8'h01 << off_i;
    end else if (mem_func_i[MF_SH]) begin
      wdata_o = {4{store_data_i[15:0]}};
      wmask_o = 8'h03 << off_i;
    end else if (mem_func_i[MF_SW]) begin
      wdata_o = {2{store_data_i[31:0]}};
      wmask_o = 8'h0F << off_i;
    end else if (mem_func_i[MF_SD]) begin
      wmask_o = 8'hFF;
    end
  end

  // Lanes past byte 7 shift in as zero, which gives the zero-fill for straddling loads.
  assign field = load_data_i >> {off_i, 3'b000};

  always_comb begin
    load_value_o = ZERO_64;
    if (mem_func_i[MF_LB])       load_value_o = {{56{field[7]}}, field[7:0]};
    else if (mem_func_i[MF_LH])  load_value_o = {{48{field[15]}}, field[15:0]};
    else if (mem_func_i[MF_LW])  load_value_o = {{32{field[31]}}, field[31:0]};
    else if (mem_func_i[MF_LBU]) load_value_o = {56'd0, field[7:0]};
    else if (mem_func_i[MF_LHU]) load_value_o = {48'd0, field[15:0]};
    else if (mem_func_i[MF_LWU]) load_value_o = {32'd0, field[31:0]};
    else if (mem_func_i[MF_LD])  load_value_o = field;
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic is_half, is_word, is_dbl;
  assign is_half    = mem_func_i[MF_LH] | mem_func_i[MF_LHU] | mem_func_i[MF_SH];
  assign is_word    = mem_func_i[MF_LW] | mem_func_i[MF_LWU] | mem_func_i[MF_SW];
  assign is_dbl     = mem_func_i[MF_LD] | mem_func_i[MF_SD];
  assign misalign_o = (is_half & off_i[0]) | (is_word & (|off_i[1:0])) | (is_dbl & (|off_i));
`endif

endmodule

// File: rtl/mem_stage.sv
// M stage: issues the load/store on the dmem port, stalls until it completes,
// and registers the rd write into W. MEM_MISALIGN_CHECK_EN adds misalignW.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MEM_FUNC_W-1:0] memFuncM,
  input  logic                  RamReadEnableM,
  input  logic                  RamWriteEnableM,
  input  logic [ADDR_W-1:0]     RamReadAddrM,
  input  logic [ADDR_W-1:0]     RamWriteAddrM,
  input  logic [DATA_W-1:0]     RamWriteDataM,
  input  logic                  rdWriteEnableM,
  input  logic [4:0]            rdWriteAddrM,
  input  logic [DATA_W-1:0]     rdWriteDataM,
  input  logic                  flushM,
  mem_stage_if.master           dmem,
  output logic                  stallReqM,
  output logic                  rdWriteEnableW,
  output logic [4:0]            rdWriteAddrW,
  output logic [DATA_W-1:0]     rdWriteDataW
`ifdef MEM_MISALIGN_CHECK_EN
  , output logic                misalignW
`endif
);

  mem_state_e        state_q;
  rd_write_t         w_q, w_d;
  logic              is_load, is_store, issue_idle, misalign;
  logic              valid_c, done, stall;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       load_value;

  assign is_load  = RamReadEnableM;
  assign is_store = RamWriteEnableM;
  assign addr     = is_store ? RamWriteAddrM : RamReadAddrM;

`ifdef MEM_MISALIGN_CHECK_EN
  logic align_mis, misalign_q, misalign_d;
  assign misalign = (is_load | is_store) & align_mis;
`else
  assign misalign = 1'b0;
`endif

  mem_align u_align (
    .mem_func_i   (memFuncM),
    .off_i        (addr[2:0]),
    .store_data_i (RamWriteDataM),
    .load_data_i  (dmem.dmem_rdata),
    .wdata_o      (dmem.dmem_wdata),
    .wmask_o      (dmem.dmem_wmask),
    .load_value_o (load_value)
`ifdef MEM_MISALIGN_CHECK_EN
    , .misalign_o (align_mis)
`endif
  );

  assign issue_idle = (is_load | is_store) & ~flushM & ~misalign;

  always_comb begin
    valid_c = 1'b0;
    done    = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        valid_c = issue_idle;
        done    = issue_idle & dmem.dmem_ready & (is_store | dmem.dmem_rvalid);
        stall   = issue_idle & ~done;
      end
      ST_WAIT_ACK: begin
        valid_c = 1'b1;
        done    = dmem.dmem_ready & (is_store | dmem.dmem_rvalid);
        stall   = ~done;
      end
      ST_WAIT_DATA: begin
        done  = dmem.dmem_rvalid;
        stall = ~done;
      end
      default: ;
    endcase
  end

  // Gated with rst so a request presented during reset never reaches memory.
  assign dmem.dmem_valid = rst & valid_c;
  assign stallReqM       = rst & stall;
  assign dmem.dmem_we    = is_store;
  assign dmem.dmem_addr  = {addr[ADDR_W-1:3], 3'b000};

  always_comb begin
    w_d = '{en: 1'b0, addr: 5'd0, data: ZERO_64};
    if (!stall && !(state_q == ST_IDLE && (flushM || misalign)) && !(done && is_store)) begin
      w_d.en   = rdWriteEnableM;
      w_d.addr = rdWriteAddrM;
      w_d.data = (done && is_load) ? load_value : rdWriteDataM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      w_q     <= '{en: 1'b0, addr: 5'd0, data: ZERO_64};
    end else begin
      w_q <= w_d;
      case (state_q)
        ST_IDLE: begin
          if (issue_idle) begin
            if (!dmem.dmem_ready)                         state_q <= ST_WAIT_ACK;
            else if (!is_store && !dmem.dmem_rvalid)      state_q <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_ACK: begin
          if (dmem.dmem_ready)
            state_q <= (is_store || dmem.dmem_rvalid) ? ST_IDLE : ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (dmem.dmem_rvalid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdWriteEnableW = w_q.en;
  assign rdWriteAddrW   = w_q.addr;
  assign rdWriteDataW   = w_q.data;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_d = (state_q == ST_IDLE) & ~flushM & misalign;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end

  assign misalignW = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: stimulus pushes expected requests,
// stall counts and W writes; a negedge monitor pops and compares them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [MEM_FUNC_W-1:0] memFuncM;
  logic                  RamReadEnableM, RamWriteEnableM;
  logic [63:0]           RamReadAddrM, RamWriteAddrM, RamWriteDataM;
  logic                  rdWriteEnableM;
  logic [4:0]            rdWriteAddrM;
  logic [63:0]           rdWriteDataM;
  logic                  flushM;
  logic                  stallReqM, rdWriteEnableW;
  logic [4:0]            rdWriteAddrW;
  logic [63:0]           rdWriteDataW;
`ifdef MEM_MISALIGN_CHECK_EN
  logic                  misalignW;
`endif

  mem_stage_if dmem_if ();

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .memFuncM        (memFuncM),
    .RamReadEnableM  (RamReadEnableM),
    .RamWriteEnableM (RamWriteEnableM),
    .RamReadAddrM    (RamReadAddrM),
    .RamWriteAddrM   (RamWriteAddrM),
    .RamWriteDataM   (RamWriteDataM),
    .rdWriteEnableM  (rdWriteEnableM),
    .rdWriteAddrM    (rdWriteAddrM),
    .rdWriteDataM    (rdWriteDataM),
    .flushM          (flushM),
    .dmem            (dmem_if),
    .stallReqM       (stallReqM),
    .rdWriteEnableW  (rdWriteEnableW),
    .rdWriteAddrW    (rdWriteAddrW),
    .rdWriteDataW    (rdWriteDataW)
`ifdef MEM_MISALIGN_CHECK_EN
    , .misalignW     (misalignW)
`endif
  );

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
    bit          full;
    bit          mis;
  } w_exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_exp_t;

  w_exp_t   w_q[$];
  req_exp_t req_q[$];
  int       stall_q[$];

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 0, instr_active = 0, w_pending = 0;
  int cur_stalls = 0, txn = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // Reference model: access size, signedness, byte-wise lane rules.
  function automatic int fsize(int f);
    case (f)
      0, 4, 7: return 1;
      1, 5, 8: return 2;
      2, 6, 9: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] ref_load(int f, int off, logic [63:0] rd);
    int n = fsize(f);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (f <= 2 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic ref_store(int f, int off, logic [63:0] d,
                           output logic [63:0] wd, output logic [7:0] wm);
    int n = fsize(f);
    for (int lane = 0; lane < 8; lane++) begin
      wd[8*lane +: 8] = d[8*(lane % n) +: 8];
      wm[lane] = (n == 8) ? 1'b1 : (lane >= off && lane < off + n);
    end
  endtask

  function automatic bit ref_misalign(int f, int off);
    return (off % fsize(f)) != 0;
  endfunction

  // Monitor: checks requests on every valid cycle, counts stalls, then W one edge later.
  w_exp_t   m_w;
  req_exp_t m_r;
  always @(negedge clk) begin
    if (mon_en) begin
      if (w_pending) begin
        w_pending = 0;
        if (w_q.size() == 0) fail_now("w_underflow");
        else begin
          m_w = w_q.pop_front();
          chk("w_en", rdWriteEnableW, m_w.en);
          if (m_w.full) begin
            chk("w_addr", rdWriteAddrW, m_w.addr);
            chk("w_data", rdWriteDataW, m_w.data);
          end
`ifdef MEM_MISALIGN_CHECK_EN
          chk("w_misalign", misalignW, m_w.mis);
`endif
          $display("txn %0d: W en=%0b rd=%0d data=%h", txn, rdWriteEnableW, rdWriteAddrW, rdWriteDataW);
          txn++;
        end
      end
      if (dmem_if.dmem_valid) begin
        if (req_q.size() == 0) fail_now("unexpected_req");
        else begin
          m_r = req_q[0];
          chk("req_addr", dmem_if.dmem_addr, m_r.addr);
          chk("req_we", dmem_if.dmem_we, m_r.we);
          if (m_r.we) begin
            chk("req_wdata", dmem_if.dmem_wdata, m_r.wdata);
            chk("req_wmask", dmem_if.dmem_wmask, m_r.wmask);
          end
          if (dmem_if.dmem_ready) void'(req_q.pop_front());
        end
      end
      if (instr_active) begin
        if (stallReqM) cur_stalls++;
        else begin
          if (stall_q.size() == 0) fail_now("stall_underflow");
          else chk("stall_cycles", cur_stalls, stall_q.pop_front());
          cur_stalls = 0;
          w_pending  = 1;
        end
      end
    end
  end

  task automatic drive_idle();
    memFuncM = '0; RamReadEnableM = 0; RamWriteEnableM = 0;
    RamReadAddrM = '0; RamWriteAddrM = '0; RamWriteDataM = '0;
    rdWriteEnableM = 0; rdWriteAddrM = '0; rdWriteDataM = '0; flushM = 0;
    dmem_if.dmem_ready = 0; dmem_if.dmem_rvalid = 0; dmem_if.dmem_rdata = '0;
  endtask

  task automatic idle_cycle();
    instr_active = 0;
    drive_idle();
    @(posedge clk); #1;
  endtask

  // One M-stage instruction; the bench plays the memory with the given delays.
  task automatic do_instr(bit mem, int f, logic [63:0] a, logic [63:0] d,
                          logic rden, logic [4:0] rda, logic [63:0] rdd,
                          bit flush, int rdelay, int ddelay, logic [63:0] rdata);
    bit ld = mem && f <= 6;
    bit st = mem && f >= 7;
    int off = int'(a[2:0]);
    bit mis = 0;
    bit issue;
    int cycles;
    w_exp_t   we;
    req_exp_t re;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = mem && !flush && ref_misalign(f, off);
`endif
    issue  = mem && !flush && !mis;
    cycles = issue ? 1 + rdelay + (ld ? ddelay : 0) : 1;
    stall_q.push_back(cycles - 1);

    we = '{en: 1'b0, addr: 5'd0, data: 64'd0, full: 1, mis: 0};
    if (mis) we.mis = 1;
    else if (flush) ;
    else if (st) we.full = 0;
    else if (ld) we = '{en: rden, addr: rda, data: ref_load(f, off, rdata), full: 1, mis: 0};
    else we = '{en: rden, addr: rda, data: rdd, full: 1, mis: 0};
    w_q.push_back(we);

    if (issue) begin
      re.addr = {a[63:3], 3'b000};
      re.we   = st;
      ref_store(f, off, d, re.wdata, re.wmask);
      req_q.push_back(re);
    end

    memFuncM = '0;
    if (mem) memFuncM[f] = 1'b1;
    RamReadEnableM  = ld;
    RamWriteEnableM = st;
    RamReadAddrM    = ld ? a : {$urandom, $urandom};
    RamWriteAddrM   = st ? a : {$urandom, $urandom};
    RamWriteDataM   = d;
    rdWriteEnableM  = rden;
    rdWriteAddrM    = rda;
    rdWriteDataM    = rdd;
    flushM          = flush;
    dmem_if.dmem_rdata = rdata;
    instr_active = 1;
    for (int c = 0; c < cycles; c++) begin
      if (issue) begin
        dmem_if.dmem_ready  = (c == rdelay);
        dmem_if.dmem_rvalid = ld && (c == rdelay + ddelay);
      end else begin
        dmem_if.dmem_ready  = 1'($urandom);
        dmem_if.dmem_rvalid = 1'($urandom);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic random_instr();
    int k = $urandom_range(0, 9);
    int f = 0;
    bit mem = 0, fl = 0;
    logic [63:0] a = {$urandom, $urandom};
    logic [2:0] m;
    int rd_dly, dt_dly;
    if (k <= 3) begin mem = 1; f = $urandom_range(0, 6); end
    else if (k <= 6) begin mem = 1; f = $urandom_range(7, 10); end
    else if (k == 9) begin mem = 1; fl = 1; f = $urandom_range(0, 10); end
    if (mem && $urandom_range(0, 1) == 1) begin
      m = 3'(fsize(f) - 1);
      a[2:0] = a[2:0] & ~m;
    end
    rd_dly = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
    dt_dly = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
    do_instr(mem, f, a, {$urandom, $urandom}, 1'($urandom), 5'($urandom),
             {$urandom, $urandom}, fl, rd_dly, dt_dly, {$urandom, $urandom});
  endtask

  initial begin
    rst = 0;
    drive_idle();
    #3;
    chk("rst_valid", dmem_if.dmem_valid, 0);
    chk("rst_stall", stallReqM, 0);
    chk("rst_w_en", rdWriteEnableW, 0);
    chk("rst_w_data", rdWriteDataW, 0);
    memFuncM = 11'h001; RamReadEnableM = 1; dmem_if.dmem_ready = 1;
    #1;
    chk("rst_valid_held", dmem_if.dmem_valid, 0);
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    mon_en = 1;

    do_instr(1, 7, 64'h1003, 64'hAB, 1, 5'd3, 64'h0, 0, 0, 0, 64'h0);
    do_instr(1, 0, 64'h2006, 64'h0, 1, 5'd9, 64'h0, 0, 0, 2, 64'h0080_0000_0000_0000);
    do_instr(1, 10, 64'h4008, 64'h0123_4567_89AB_CDEF, 1, 5'd2, 64'h0, 0, 3, 0, 64'h0);
    do_instr(0, 0, 64'h0, 64'h0, 1, 5'd5, 64'h1234, 0, 0, 0, 64'h0);
    do_instr(1, 2, 64'h5000, 64'h0, 1, 5'd7, 64'h0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    do_instr(1, 1, 64'h6007, 64'h0, 1, 5'd8, 64'h0, 0, 1, 1, 64'h8811_2233_4455_6677);
`ifdef MEM_MISALIGN_CHECK_EN
    do_instr(1, 2, 64'h3002, 64'h0, 1, 5'd4, 64'h0, 0, 0, 0, 64'h0);
`endif
    for (int i = 0; i < 250; i++) random_instr();
    idle_cycle();
    idle_cycle();
    mon_en = 0;

    // Reset with a live W write: W must clear without waiting for a clock.
    rdWriteEnableM = 1; rdWriteAddrM = 5'd6; rdWriteDataM = 64'h55;
    @(posedge clk); #1;
    chk("rstA_pre_en", rdWriteEnableW, 1);
    drive_idle();
    #1 rst = 0;
    #1;
    chk("rstA_w_en", rdWriteEnableW, 0);
    chk("rstA_w_addr", rdWriteAddrW, 0);
    chk("rstA_w_data", rdWriteDataW, 0);
    @(posedge clk); #1 rst = 1;

    // Reset while waiting for load data.
    memFuncM = 11'h001; RamReadEnableM = 1; RamReadAddrM = 64'h40;
    rdWriteEnableM = 1; rdWriteAddrM = 5'd4; dmem_if.dmem_ready = 1;
    @(posedge clk); #1;
    dmem_if.dmem_ready = 0;
    chk("rstB_pre_stall", stallReqM, 1);
    chk("rstB_pre_valid", dmem_if.dmem_valid, 0);
    #1 rst = 0;
    #1;
    chk("rstB_valid", dmem_if.dmem_valid, 0);
    chk("rstB_stall", stallReqM, 0);
    chk("rstB_w_en", rdWriteEnableW, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("rstB_misalign", misalignW, 0);
`endif
    @(posedge clk); #1;
    drive_idle();
    rst = 1;
    #1;
    chk("post_rst_stall", stallReqM, 0);
    dmem_if.dmem_rvalid = 1;
    dmem_if.dmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("stray_rvalid_stall", stallReqM, 0);
    @(posedge clk); #1;
    chk("stray_rvalid_w_en", rdWriteEnableW, 0);
    dmem_if.dmem_rvalid = 0;

    mon_en = 1;
    for (int i = 0; i < 20; i++) random_instr();
    idle_cycle();
    idle_cycle();
    chk("w_q_drained", w_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    chk("stall_q_drained", stall_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
